// File: rtl/conway_loader_if.sv
// Row-beat stream into the loader and the committed-board outputs toward the game-of-life core.
// master = upstream row source / board consumer, slave = conway_loader.
interface conway_loader_if #(
    parameter int ROWS = 16,
    parameter int COLS = 16
);
    logic                   s_valid;
    logic                   s_ready;
    logic                   s_sof;
    logic [COLS-1:0]        s_row;
    logic                   load;
    logic [ROWS*COLS-1:0]   data;
    logic                   sync_err;
    logic [15:0]            frame_count;

    modport master (
        output s_valid, s_sof, s_row,
        input  s_ready, load, data, sync_err, frame_count
    );

    modport slave (
        input  s_valid, s_sof, s_row,
        output s_ready, load, data, sync_err, frame_count
    );
endinterface

// File: rtl/conway_loader.sv
// Assembles one board row per accepted beat and commits the full image in a one-cycle load strobe.
// A start-of-frame beat always restarts assembly at row 0; abandoning a partial frame raises sync_err.
module conway_loader #(
    parameter int ROWS = 16,
    parameter int COLS = 16
) (
    input  logic           clk,
    input  logic           rst,
    conway_loader_if.slave bus
);
    localparam int IDXW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {
        COLLECT = 1'b0,
        COMMIT  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDXW-1:0]      rowIdx_q, rowIdx_d;
    logic [IDXW-1:0]      effRow;
    logic [ROWS*COLS-1:0] buffer_q, buffer_d;
    logic [ROWS*COLS-1:0] data_q, data_d;
    logic [15:0]          frameCount_q, frameCount_d;
    logic                 syncErr_q, syncErr_d;
    logic                 accept;

    // Ready is held low while reset is asserted so beats offered then are never taken.
    assign bus.s_ready     = (state_q == COLLECT) && !rst;
    assign accept          = bus.s_valid && bus.s_ready;
    assign effRow          = bus.s_sof ? '0 : rowIdx_q;

    assign bus.load        = (state_q == COMMIT);
    assign bus.data        = data_q;
    assign bus.sync_err    = syncErr_q;
    assign bus.frame_count = frameCount_q;

    always_comb begin
        state_d      = state_q;
        rowIdx_d     = rowIdx_q;
        buffer_d     = buffer_q;
        data_d       = data_q;
        frameCount_d = frameCount_q;
        syncErr_d    = 1'b0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (effRow == IDXW'(r)) begin
                            buffer_d[r*COLS +: COLS] = bus.s_row;
                        end
                    end
                    syncErr_d = bus.s_sof && (rowIdx_q != '0);
                    // data captures buffer_d so the final row is part of the committed image.
                    if (effRow == IDXW'(ROWS - 1)) begin
                        rowIdx_d     = '0;
                        state_d      = COMMIT;
                        data_d       = buffer_d;
                        frameCount_d = frameCount_q + 16'd1;
                    end else begin
                        rowIdx_d = effRow + IDXW'(1);
                    end
                end
            end
            COMMIT: begin
                state_d = COLLECT;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            rowIdx_q     <= '0;
            buffer_q     <= '0;
            data_q       <= '0;
            frameCount_q <= '0;
            syncErr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rowIdx_q     <= rowIdx_d;
            buffer_q     <= buffer_d;
            data_q       <= data_d;
            frameCount_q <= frameCount_d;
            syncErr_q    <= syncErr_d;
        end
    end
endmodule

// File: tb/tb_conway_loader.sv
// Directed bench for conway_loader: full frames, gaps, resync, stability, reset, counter wrap, ROWS=1.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_conway_loader;
    localparam int ROWS = 16;
    localparam int COLS = 16;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    logic [ROWS*COLS-1:0] expData;
    logic [15:0] glider [ROWS];

    always #5 clk = ~clk;

    conway_loader_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
    conway_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    conway_loader_if #(.ROWS(1), .COLS(4)) smallBus ();
    conway_loader #(.ROWS(1), .COLS(4)) smallDut (
        .clk (clk),
        .rst (rst),
        .bus (smallBus)
    );

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            passed++;
        end
    endtask

    // Drive one cycle of stimulus, then land 1 ns past the edge that consumed it.
    task automatic applyStimulus(input logic v, input logic sof, input logic [15:0] row);
        bus.s_valid = v;
        bus.s_sof   = sof;
        bus.s_row   = row;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_sof   = 1'b1;
        bus.s_row   = 16'hBEEF;
        smallBus.s_valid = 1'b0;
        smallBus.s_sof   = 1'b0;
        smallBus.s_row   = 4'h0;
        @(posedge clk);
        #1;
        checkOutput("rst_ready", 256'(bus.s_ready), 256'(0));
        @(posedge clk);
        #1;
        checkOutput("rst_load", 256'(bus.load), 256'(0));
        checkOutput("rst_data", 256'(bus.data), 256'(0));
        checkOutput("rst_fc", 256'(bus.frame_count), 256'(0));
        checkOutput("rst_err", 256'(bus.sync_err), 256'(0));
        bus.s_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("ready_after_rst", 256'(bus.s_ready), 256'(1));

        // Full back-to-back frame, row r = 0x0101*r.
        expData = '0;
        for (int r = 0; r < ROWS; r++) begin
            checkOutput("t2_ready", 256'(bus.s_ready), 256'(1));
            applyStimulus(1'b1, (r == 0), 16'(16'h0101 * r));
            expData[r*16 +: 16] = 16'(16'h0101 * r);
            if (r == 0) checkOutput("t2_sof0_noerr", 256'(bus.sync_err), 256'(0));
            if (r < ROWS - 1) checkOutput("t2_noload", 256'(bus.load), 256'(0));
        end
        checkOutput("t2_load", 256'(bus.load), 256'(1));
        checkOutput("t2_ready_commit", 256'(bus.s_ready), 256'(0));
        checkOutput("t2_fc", 256'(bus.frame_count), 256'(1));
        checkOutput("t2_data", 256'(bus.data), 256'(expData));
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("t2_load_off", 256'(bus.load), 256'(0));
        checkOutput("t2_ready_back", 256'(bus.s_ready), 256'(1));

        // Same frame with gaps and no sof; a beat offered during COMMIT becomes row 0 of the next frame.
        for (int r = 0; r < ROWS; r++) begin
            applyStimulus(1'b1, 1'b0, 16'(16'h0101 * r));
            if (r < ROWS - 1 && (r % 2) == 0) applyStimulus(1'b0, 1'b1, 16'hDEAD);
            if (r < ROWS - 1) checkOutput("t3_noload", 256'(bus.load), 256'(0));
        end
        checkOutput("t3_load", 256'(bus.load), 256'(1));
        checkOutput("t3_data", 256'(bus.data), 256'(expData));
        checkOutput("t3_fc", 256'(bus.frame_count), 256'(2));
        applyStimulus(1'b1, 1'b0, 16'h1234);
        checkOutput("t3_held_load", 256'(bus.load), 256'(0));
        checkOutput("t3_held_ready", 256'(bus.s_ready), 256'(1));
        checkOutput("t3_held_data", 256'(bus.data), 256'(expData));
        applyStimulus(1'b1, 1'b0, 16'h1234);
        for (int r = 1; r < ROWS; r++) begin
            if (r < ROWS) checkOutput("t3b_noload", 256'(bus.load), 256'(0));
            applyStimulus(1'b1, 1'b0, 16'h0000);
        end
        checkOutput("t3b_load", 256'(bus.load), 256'(1));
        checkOutput("t3b_data", 256'(bus.data), 256'h1234);
        checkOutput("t3b_fc", 256'(bus.frame_count), 256'(3));

        // Resync: five rows, then sof 0xFFFF, then fifteen zero rows.
        for (int r = 0; r < 5; r++) begin
            applyStimulus(1'b1, 1'b0, 16'h00F0);
            checkOutput("t4_noload", 256'(bus.load), 256'(0));
        end
        applyStimulus(1'b1, 1'b1, 16'hFFFF);
        checkOutput("t4_syncerr", 256'(bus.sync_err), 256'(1));
        checkOutput("t4_noload_sof", 256'(bus.load), 256'(0));
        for (int r = 1; r < ROWS; r++) begin
            applyStimulus(1'b1, 1'b0, 16'h0000);
            if (r == 1) checkOutput("t4_syncerr_pulse", 256'(bus.sync_err), 256'(0));
            if (r < ROWS - 1) checkOutput("t4_noload2", 256'(bus.load), 256'(0));
        end
        checkOutput("t4_load", 256'(bus.load), 256'(1));
        checkOutput("t4_data", 256'(bus.data), 256'hFFFF);
        checkOutput("t4_fc", 256'(bus.frame_count), 256'(4));
        applyStimulus(1'b0, 1'b0, 16'h0000);

        // Glider commit, then ten beats that never complete a frame.
        expData = '0;
        for (int r = 0; r < ROWS; r++) glider[r] = 16'h0000;
        glider[1] = 16'h0002;
        glider[2] = 16'h0004;
        glider[3] = 16'h0007;
        for (int r = 0; r < ROWS; r++) begin
            applyStimulus(1'b1, (r == 0), glider[r]);
            expData[r*16 +: 16] = glider[r];
        end
        checkOutput("t5_load", 256'(bus.load), 256'(1));
        checkOutput("t5_data", 256'(bus.data), 256'(expData));
        checkOutput("t5_fc", 256'(bus.frame_count), 256'(5));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(i * 16'h1357 + 1));
            checkOutput("t5_stable_load", 256'(bus.load), 256'(0));
            checkOutput("t5_stable_data", 256'(bus.data), 256'(expData));
        end

        // Reset mid-frame with a beat offered during reset, then a fresh 0xAAAA frame.
        rst = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_sof   = 1'b0;
        bus.s_row   = 16'h5555;
        #1;
        checkOutput("t6_rst_ready", 256'(bus.s_ready), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t6_data", 256'(bus.data), 256'(0));
        checkOutput("t6_fc", 256'(bus.frame_count), 256'(0));
        checkOutput("t6_load", 256'(bus.load), 256'(0));
        for (int r = 0; r < ROWS; r++) begin
            applyStimulus(1'b1, 1'b0, 16'hAAAA);
            checkOutput("t6_noerr", 256'(bus.sync_err), 256'(0));
            if (r < ROWS - 1) checkOutput("t6_noload", 256'(bus.load), 256'(0));
        end
        checkOutput("t6_load_frame", 256'(bus.load), 256'(1));
        checkOutput("t6_data_frame", 256'(bus.data), 256'({16{16'hAAAA}}));
        checkOutput("t6_fc_frame", 256'(bus.frame_count), 256'(1));
        applyStimulus(1'b0, 1'b0, 16'h0000);

        // Preload the counter near its limit, then commit two frames across the wrap.
        force dut.frameCount_q = 16'hFFFE;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        release dut.frameCount_q;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < ROWS; r++) applyStimulus(1'b1, (r == 0), 16'h0F0F);
            checkOutput("t7_load", 256'(bus.load), 256'(1));
            checkOutput("t7_fc", 256'(bus.frame_count), (f == 0) ? 256'hFFFF : 256'h0000);
            applyStimulus(1'b0, 1'b0, 16'h0000);
        end

        // ROWS=1: every accepted beat commits.
        smallBus.s_valid = 1'b1;
        smallBus.s_row   = 4'h9;
        @(posedge clk);
        #1;
        checkOutput("t8_load1", 256'(smallBus.load), 256'(1));
        checkOutput("t8_data1", 256'(smallBus.data), 256'h9);
        checkOutput("t8_fc1", 256'(smallBus.frame_count), 256'(1));
        checkOutput("t8_ready1", 256'(smallBus.s_ready), 256'(0));
        smallBus.s_row = 4'h6;
        @(posedge clk);
        #1;
        checkOutput("t8_gap_load", 256'(smallBus.load), 256'(0));
        checkOutput("t8_gap_data", 256'(smallBus.data), 256'h9);
        @(posedge clk);
        #1;
        smallBus.s_valid = 1'b0;
        checkOutput("t8_load2", 256'(smallBus.load), 256'(1));
        checkOutput("t8_data2", 256'(smallBus.data), 256'h6);
        checkOutput("t8_fc2", 256'(smallBus.frame_count), 256'(2));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/conway_loader.md
CONWAY_LOADER -- requirements
Module: conway_loader

Interface
REQ-001 Parameter ROWS, default 16: board height in cells.
REQ-002 Parameter COLS, default 16: board width in cells; row beat width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  1  upstream row beat valid.
REQ-006 s_ready  output  1  loader accepts beat this cycle.
REQ-007 s_sof  input  1  start-of-frame marker; qualified by s_valid.
REQ-008 s_row  input  COLS  one board row; bit c = column c.
REQ-009 load  output  1  one-cycle commit strobe to the game-of-life core.
REQ-010 data  output  ROWS*COLS  committed board image.
REQ-011 sync_err  output  1  one-cycle pulse: partial frame discarded.
REQ-012 frame_count  output  16  committed frames, modulo 2^16.

Function
REQ-013 Beat accepted iff s_valid && s_ready at a rising edge; no other beat is stored.
REQ-014 Two states only: COLLECT (s_ready=1), COMMIT (s_ready=0).
REQ-015 Internal assembly buffer (ROWS*COLS) and row index (0..ROWS-1) separate from the data register.
REQ-016 In COLLECT, accepted beat at row index r writes buffer bits [r*COLS+COLS-1 : r*COLS]; bit r*COLS+c = s_row[c].
REQ-017 Rows arrive row 0 first; row index increments by 1 per accepted beat.
REQ-018 Accepted beat with row index ROWS-1: row index -> 0, state -> COMMIT.
REQ-019 In COMMIT (exactly one cycle): load=1; data equals complete buffer, including the final row; frame_count increments; state -> COLLECT.
REQ-020 Latency: final row accepted at edge N -> load high in cycle N+1 -> s_ready high again in cycle N+2.
REQ-021 data changes only on entry to COMMIT; data stable between commits regardless of input activity.
REQ-022 load is 0 in every cycle except COMMIT; never high for two consecutive cycles.
REQ-023 Accepted beat with s_sof=1 is always stored as row 0; row index -> 1.
REQ-024 s_sof=1 accepted while row index != 0: previous partial rows discarded; sync_err=1 in the following cycle; no load for the discarded frame.
REQ-025 s_sof=1 accepted at row index 0: normal, no sync_err.
REQ-026 s_sof=0 on first beat of a frame: accepted as row 0, no error.
REQ-027 s_sof and s_row ignored while s_valid=0 or s_ready=0.
REQ-028 Buffer rows not rewritten after a resync retain stale contents until overwritten; each committed frame has every row written since the last row-0 beat.
REQ-029 frame_count wraps 0xFFFF -> 0x0000, no flag.
REQ-030 ROWS=1: every accepted beat commits.

Reset
REQ-031 rst high at an edge: state COLLECT, row index 0, load=0, sync_err=0, data=0, buffer=0, frame_count=0.
REQ-032 s_ready=0 in any cycle where rst=1; beats presented during reset are dropped.
REQ-033 Reset during COMMIT or mid-frame overrides everything: no load the next cycle; partial frame lost; no sync_err.
REQ-034 First beat after reset deassertion is treated as row 0.

Verification
REQ-035 Full frame: 16 back-to-back beats, s_row=r replicated (row r = 16'h0101*r) -> load=1 exactly one cycle after beat 15, data[r*16+:16]=16'h0101*r, frame_count=1, s_ready=0 that cycle.
REQ-036 Backpressure/gaps: same frame with s_valid toggled 1-0-1; beat held during COMMIT -> identical data; beat presented in COMMIT accepted next cycle as row 0 of frame 2.
REQ-037 Resync: 5 rows, then s_sof beat 16'hFFFF, then 15 rows of 0 -> sync_err pulse one cycle after s_sof beat; single load; data[15:0]=16'hFFFF; frame_count=1.
REQ-038 Data stability: after commit of glider pattern, 10 beats without completion -> data unchanged, load=0 throughout.
REQ-039 Reset mid-frame: 8 rows, rst 1 cycle, 16 rows of 16'hAAAA -> one load, data all 16'hAAAA, frame_count=1, no sync_err.
REQ-040 Wrap: force 65536 commits -> frame_count returns to 0x0000 on the 65536th load.
